// File: rtl/sf_camera_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sf_camera_pkg
//  Description : Shared types and constants for the sf_camera receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package sf_camera_pkg;

    // Capture FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_VS_HIGH = 2'd1,
        ST_WAIT_VS_LOW  = 2'd2,
        ST_CAPTURE      = 2'd3
    } cap_state_t;

    // The camera sends the high byte of each RGB565 pixel first
    localparam bit C_RGB565_FIRST_IS_HIGH = 1'b1;

    // Default active pixels per line
    localparam int C_DEFAULT_IMAGE_WIDTH = 640;

    // Flip-flops per asynchronous input
    localparam int C_SYNC_DEPTH = 2;

    // Join the two received bytes of a pixel in RGB565 order
    function automatic logic [15:0] rgb565_pack(input logic [7:0] first_byte,
                                                input logic [7:0] second_byte);
        return C_RGB565_FIRST_IS_HIGH ? {first_byte, second_byte}
                                      : {second_byte, first_byte};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sf_camera_pixel_capture_if.sv
`default_nettype none
// ============================================================================
//  Interface   : sf_camera_pixel_capture_if
//  Description : Pixel stream (valid/ready) with frame-start/line-end markers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sf_camera_pixel_capture_if;

    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        frame_start;
    logic        line_end;

    // Producer side (capture block)
    modport master (
        output pixel_data,
        output pixel_valid,
        output frame_start,
        output line_end,
        input  pixel_ready
    );

    // Consumer side (pixel FIFO)
    modport slave (
        input  pixel_data,
        input  pixel_valid,
        input  frame_start,
        input  line_end,
        output pixel_ready
    );

endinterface
`default_nettype wire

// File: rtl/sf_camera_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sf_camera_sync
//  Description : Parameterizable-width multi-flop synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module sf_camera_sync
    import sf_camera_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = C_SYNC_DEPTH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sf_camera_pixel_capture.sv
`default_nettype none
// ============================================================================
//  Module      : sf_camera_pixel_capture
//  Description : Samples the camera pclk/vsync/href/data in the system clock
//                domain, pairs bytes into RGB565 pixels and presents them on a
//                single-entry valid/ready stream with frame/line markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module sf_camera_pixel_capture
    import sf_camera_pkg::*;
#(
    parameter int IMAGE_WIDTH   = C_DEFAULT_IMAGE_WIDTH,
    parameter int PIX_CNT_WIDTH = 12
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          i_enable,
    input  wire logic                          i_cam_pclk,
    input  wire logic                          i_cam_vsync,
    input  wire logic                          i_cam_href,
    input  wire logic [7:0]                    i_cam_data,
    sf_camera_pixel_capture_if.master          pix,
    output logic      [15:0]                   o_frame_count,
    output logic                               o_overflow,
    output logic                               o_busy
);

    localparam logic [PIX_CNT_WIDTH-1:0] C_LAST_PIX = PIX_CNT_WIDTH'(IMAGE_WIDTH - 1);

    logic [10:0]              w_sync_q;
    logic                     r_pclk_d;
    logic                     r_pclk_rise;
    logic                     r_vsync;
    logic                     r_vsync_prev;
    logic                     r_href;
    logic                     r_href_prev;
    logic [7:0]               r_data;
    cap_state_t               r_state;
    cap_state_t               w_state_next;
    logic                     r_phase;
    logic [7:0]               r_high;
    logic [PIX_CNT_WIDTH-1:0] r_pix_cnt;
    logic                     r_first_pix;
    logic                     w_vsync_rise;
    logic                     w_href_fall;
    logic                     w_enter_capture;
    logic                     w_pixel_form;
    logic                     w_accept;

    sf_camera_sync #(
        .WIDTH (11),
        .DEPTH (C_SYNC_DEPTH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d ({i_cam_pclk, i_cam_vsync, i_cam_href, i_cam_data}),
        .o_q (w_sync_q)
    );

    // Edge-detect pclk and keep data/href/vsync aligned with the rise strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pclk_d     <= 1'b0;
            r_pclk_rise  <= 1'b0;
            r_vsync      <= 1'b0;
            r_vsync_prev <= 1'b0;
            r_href       <= 1'b0;
            r_href_prev  <= 1'b0;
            r_data       <= 8'd0;
        end else begin
            r_pclk_d     <= w_sync_q[10];
            r_pclk_rise  <= w_sync_q[10] & ~r_pclk_d;
            r_vsync      <= w_sync_q[9];
            r_vsync_prev <= r_vsync;
            r_href       <= w_sync_q[8];
            r_href_prev  <= r_href;
            r_data       <= w_sync_q[7:0];
        end
    end

    assign w_vsync_rise    = r_vsync & ~r_vsync_prev;
    assign w_href_fall     = r_href_prev & ~r_href;
    assign w_enter_capture = (r_state != ST_CAPTURE) && (w_state_next == ST_CAPTURE);
    assign w_pixel_form    = (r_state == ST_CAPTURE) && r_pclk_rise && r_href && r_phase;
    assign w_accept        = pix.pixel_valid & pix.pixel_ready;
    assign o_busy          = (r_state == ST_CAPTURE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next state; a frame in progress always runs to its closing vsync
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:         if (i_enable) w_state_next = ST_WAIT_VS_HIGH;
            ST_WAIT_VS_HIGH: if (!i_enable)    w_state_next = ST_IDLE;
                             else if (r_vsync) w_state_next = ST_WAIT_VS_LOW;
            ST_WAIT_VS_LOW:  if (!i_enable)     w_state_next = ST_IDLE;
                             else if (!r_vsync) w_state_next = ST_CAPTURE;
            ST_CAPTURE:      if (w_vsync_rise)
                                 w_state_next = i_enable ? ST_WAIT_VS_LOW : ST_IDLE;
            default:         w_state_next = ST_IDLE;
        endcase
    end

    // Byte pairing, pixel position and first-pixel-of-frame tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= 1'b0;
            r_high      <= 8'd0;
            r_pix_cnt   <= '0;
            r_first_pix <= 1'b0;
        end else if (w_enter_capture) begin
            r_phase     <= 1'b0;
            r_pix_cnt   <= '0;
            r_first_pix <= 1'b1;
        end else if (r_state == ST_CAPTURE) begin
            if (!r_href) begin
                r_phase <= 1'b0;
            end else if (r_pclk_rise) begin
                if (!r_phase) r_high <= r_data;
                r_phase <= ~r_phase;
            end
            if (w_href_fall)       r_pix_cnt <= '0;
            else if (w_pixel_form) r_pix_cnt <= r_pix_cnt + PIX_CNT_WIDTH'(1);
            if (w_pixel_form)      r_first_pix <= 1'b0;
        end
    end

    // Single-entry output register; a pixel arriving while one is stalled is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            pix.pixel_valid <= 1'b0;
            pix.pixel_data  <= 16'd0;
            pix.frame_start <= 1'b0;
            pix.line_end    <= 1'b0;
            o_overflow      <= 1'b0;
        end else if (w_pixel_form) begin
            if (pix.pixel_valid && !pix.pixel_ready) begin
                o_overflow <= 1'b1;
            end else begin
                pix.pixel_valid <= 1'b1;
                pix.pixel_data  <= rgb565_pack(r_high, r_data);
                pix.frame_start <= r_first_pix;
                pix.line_end    <= (r_pix_cnt == C_LAST_PIX);
            end
        end else if (w_accept) begin
            pix.pixel_valid <= 1'b0;
        end
    end

    // Completed-frame counter, bumped by the vsync that closes a frame
    always_ff @(posedge clk) begin
        if (rst)                                      o_frame_count <= 16'd0;
        else if (r_state == ST_CAPTURE && w_vsync_rise) o_frame_count <= o_frame_count + 16'd1;
    end

endmodule
`default_nettype wire

// File: tb/tb_sf_camera_pixel_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sf_camera_pixel_capture
//  Description : Directed self-checking bench for sf_camera_pixel_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sf_camera_pixel_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'd0;
    logic [15:0] frame_count;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] pix_q [$];

    sf_camera_pixel_capture_if pix_if ();

    sf_camera_pixel_capture #(
        .IMAGE_WIDTH   (4),
        .PIX_CNT_WIDTH (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (enable),
        .i_cam_pclk    (cam_pclk),
        .i_cam_vsync   (cam_vsync),
        .i_cam_href    (cam_href),
        .i_cam_data    (cam_data),
        .pix           (pix_if.master),
        .o_frame_count (frame_count),
        .o_overflow    (overflow),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    // Record every transferred pixel as {frame_start, line_end, data}
    always @(negedge clk) begin
        if (!rst && pix_if.pixel_valid && pix_if.pixel_ready)
            pix_q.push_back({pix_if.frame_start, pix_if.line_end, pix_if.pixel_data});
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One camera byte at pclk = clk/5: data set while pclk low, then pclk high
    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        tick(3);
        cam_pclk = 1'b1;
        tick(2);
    endtask

    task automatic send_line(input logic [63:0] bytes, input int n);
        cam_href = 1'b1;
        for (int i = 0; i < n; i++) send_byte(bytes[8*(n-1-i) +: 8]);
        cam_pclk = 1'b0;
        tick(3);
        cam_href = 1'b0;
        tick(8);
    endtask

    task automatic vsync_pulse;
        cam_vsync = 1'b1;
        tick(8);
        cam_vsync = 1'b0;
        tick(8);
    endtask

    task automatic expect_pix(input string tag, input logic [15:0] d,
                              input logic fs, input logic le);
        logic [17:0] got;
        got = (pix_q.size() > 0) ? pix_q.pop_front() : 18'h3FFFF;
        chk(tag, 32'(got), 32'({fs, le, d}));
    endtask

    initial begin
        int lat;
        pix_if.pixel_ready = 1'b1;
        tick(3);
        chk("rst_valid", 32'(pix_if.pixel_valid), 0);
        chk("rst_data", 32'(pix_if.pixel_data), 0);
        chk("rst_fcount", 32'(frame_count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // Basic line with latency measurement on the second byte
        enable = 1'b1;
        tick(2);
        vsync_pulse();
        chk("busy_capture", 32'(busy), 1);
        cam_href = 1'b1;
        send_byte(8'h12);
        cam_data = 8'h34;
        cam_pclk = 1'b0;
        tick(3);
        cam_pclk = 1'b1;
        lat = 0;
        while (!pix_if.pixel_valid && lat < 20) begin
            tick(1);
            lat++;
        end
        chk("valid_latency", 32'(lat), 4);
        tick(1);
        send_byte(8'h56);
        send_byte(8'h78);
        cam_pclk = 1'b0;
        tick(3);
        cam_href = 1'b0;
        tick(8);
        expect_pix("basic_px0", 16'h1234, 1'b1, 1'b0);
        expect_pix("basic_px1", 16'h5678, 1'b0, 1'b0);
        chk("basic_count", 32'(pix_q.size()), 0);

        // Frame 2: line_end on the 4th pixel only
        vsync_pulse();
        chk("fcount_1", 32'(frame_count), 1);
        send_line(64'h0102030405060708, 8);
        expect_pix("le_px0", 16'h0102, 1'b1, 1'b0);
        expect_pix("le_px1", 16'h0304, 1'b0, 1'b0);
        expect_pix("le_px2", 16'h0506, 1'b0, 1'b0);
        expect_pix("le_px3", 16'h0708, 1'b0, 1'b1);

        // Frame 3: odd trailing byte dropped, next line re-pairs
        vsync_pulse();
        chk("fcount_2", 32'(frame_count), 2);
        send_line(64'hAABBCC, 3);
        send_line(64'h1122, 2);
        expect_pix("odd_px0", 16'hAABB, 1'b1, 1'b0);
        expect_pix("odd_px1", 16'h1122, 1'b0, 1'b0);
        chk("odd_count", 32'(pix_q.size()), 0);

        // Frame 4: backpressure and sticky overflow
        vsync_pulse();
        chk("fcount_3", 32'(frame_count), 3);
        pix_if.pixel_ready = 1'b0;
        cam_href = 1'b1;
        send_byte(8'hA1);
        send_byte(8'hB2);
        cam_pclk = 1'b0;
        tick(3);
        chk("bp_valid", 32'(pix_if.pixel_valid), 1);
        chk("bp_data0", 32'(pix_if.pixel_data), 32'h0000A1B2);
        chk("bp_fs", 32'(pix_if.frame_start), 1);
        chk("bp_no_ovf_yet", 32'(overflow), 0);
        send_byte(8'hC3);
        send_byte(8'hD4);
        cam_pclk = 1'b0;
        tick(3);
        chk("bp_overflow", 32'(overflow), 1);
        chk("bp_data1", 32'(pix_if.pixel_data), 32'h0000A1B2);
        send_byte(8'hE5);
        send_byte(8'hF6);
        cam_pclk = 1'b0;
        tick(3);
        cam_href = 1'b0;
        tick(8);
        chk("bp_data2", 32'(pix_if.pixel_data), 32'h0000A1B2);
        pix_if.pixel_ready = 1'b1;
        tick(3);
        expect_pix("bp_px0", 16'hA1B2, 1'b1, 1'b0);
        chk("bp_count", 32'(pix_q.size()), 0);
        chk("bp_ovf_sticky", 32'(overflow), 1);

        // Drop enable mid-frame: frame completes, then IDLE
        enable = 1'b0;
        send_line(64'h9ABC, 2);
        expect_pix("dis_px0", 16'h9ABC, 1'b0, 1'b0);
        vsync_pulse();
        chk("fcount_4", 32'(frame_count), 4);
        chk("dis_idle", 32'(busy), 0);
        send_line(64'h31323334, 4);
        chk("dis_no_pix", 32'(pix_q.size()), 0);

        // Reset in the middle of a line
        enable = 1'b1;
        tick(2);
        vsync_pulse();
        pix_if.pixel_ready = 1'b0;
        cam_href = 1'b1;
        send_byte(8'h55);
        send_byte(8'h66);
        cam_pclk = 1'b0;
        tick(3);
        chk("mr_valid_pre", 32'(pix_if.pixel_valid), 1);
        rst = 1'b1;
        tick(1);
        chk("mr_valid", 32'(pix_if.pixel_valid), 0);
        chk("mr_data", 32'(pix_if.pixel_data), 0);
        chk("mr_fs", 32'(pix_if.frame_start), 0);
        chk("mr_fcount", 32'(frame_count), 0);
        chk("mr_overflow", 32'(overflow), 0);
        chk("mr_busy", 32'(busy), 0);
        rst = 1'b0;
        cam_href = 1'b0;
        pix_if.pixel_ready = 1'b1;
        tick(10);
        chk("mr_no_pix", 32'(pix_q.size()), 0);
        vsync_pulse();
        send_line(64'hDEADBEEF, 4);
        expect_pix("mr_px0", 16'hDEAD, 1'b1, 1'b0);
        expect_pix("mr_px1", 16'hBEEF, 1'b0, 1'b0);
        vsync_pulse();
        chk("mr_fcount_1", 32'(frame_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
